// File: rtl/fm_lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : fm_lane_packer
// Description : Packs a scalar element stream into N-lane beats for the
//               feature-map reduction path. A short final beat is padded with
//               PAD so that downstream lane sums are unaffected. The element
//               count of each frame is reported alongside the frame's last beat.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               in/in_valid/in_last/in_ready     - scalar element stream
//               out/out_valid/out_last/out_ready - packed beat stream,
//                                  lane k at out[k*BITWIDTH +: BITWIDTH]
//               frame_elems       - frame element count, valid with out_last
// Revision    : 1.0 - initial release
// ============================================================================
module fm_lane_packer #(
    parameter int                  BITWIDTH = 16,
    parameter int                  N        = 8,
    parameter logic [BITWIDTH-1:0] PAD      = '0,
    parameter int                  CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BITWIDTH-1:0]   in,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [N*BITWIDTH-1:0] out,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      frame_elems
);

    localparam int                LANE_W      = (N > 1) ? $clog2(N) : 1;
    localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(N - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;

    logic [N*BITWIDTH-1:0] r_pack;
    logic [LANE_W-1:0]     r_lane_cnt;
    logic [CNT_W-1:0]      r_elem_cnt;
    logic [N*BITWIDTH-1:0] r_out;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [CNT_W-1:0]      r_frame_elems;

    logic                  w_accept;
    logic                  w_end_of_beat;
    logic [CNT_W-1:0]      w_elem_inc;
    logic [N*BITWIDTH-1:0] w_beat;
    logic [N*BITWIDTH-1:0] w_pack_next;

    // A held beat blocks input unless it retires this same cycle, so a
    // completing element can replace the retiring beat without a bubble.
    assign in_ready      = !rst && (!r_out_valid || out_ready);
    assign w_accept      = in_valid && in_ready;
    assign w_end_of_beat = (r_lane_cnt == c_LAST_LANE) || in_last;

    // Element count saturates; packing is unaffected by saturation.
    assign w_elem_inc = (r_elem_cnt == c_CNT_MAX) ? r_elem_cnt : r_elem_cnt + 1'b1;

    // Per-lane view: lanes below the fill point come from the pack register,
    // the current lane takes the incoming element, lanes above it get PAD.
    // Only used when w_accept is true, so X on an idle input never lands.
    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam logic [LANE_W-1:0] c_K = LANE_W'(k);

        assign w_beat[k*BITWIDTH +: BITWIDTH] =
            (c_K < r_lane_cnt)  ? r_pack[k*BITWIDTH +: BITWIDTH] :
            (c_K == r_lane_cnt) ? in : PAD;

        assign w_pack_next[k*BITWIDTH +: BITWIDTH] =
            (w_accept && (c_K == r_lane_cnt)) ? in : r_pack[k*BITWIDTH +: BITWIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pack        <= '0;
            r_lane_cnt    <= '0;
            r_elem_cnt    <= '0;
            r_out         <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_frame_elems <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_end_of_beat) begin
                    // Overrides the retire above when a new beat lands.
                    r_out       <= w_beat;
                    r_out_valid <= 1'b1;
                    r_out_last  <= in_last;
                    if (in_last) begin
                        r_frame_elems <= w_elem_inc;
                    end
                    r_lane_cnt  <= '0;
                    r_pack      <= '0;
                end else begin
                    r_pack      <= w_pack_next;
                    r_lane_cnt  <= r_lane_cnt + 1'b1;
                end
                r_elem_cnt <= in_last ? '0 : w_elem_inc;
            end
        end
    end

    assign out         = r_out;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign frame_elems = r_frame_elems;

endmodule
`default_nettype wire

// File: tb/tb_fm_lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fm_lane_packer
// Description : Self-checking bench for fm_lane_packer (N=8, 16-bit lanes).
//               Expected beats are built per frame from the packing rules and
//               compared against every beat handed downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_lane_packer;

    localparam int BW = 16;
    localparam int NL = 8;

    logic           clk;
    logic           rst;
    logic [BW-1:0]  in;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [127:0]   out;
    logic           out_valid;
    logic           out_last;
    logic           out_ready;
    logic [15:0]    frame_elems;

    int n_assert = 0;
    int n_fail   = 0;
    bit rnd_mode = 0;

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic [15:0]  fe;
    } beat_t;

    beat_t exp_q[$];

    fm_lane_packer #(
        .BITWIDTH (BW),
        .N        (NL),
        .PAD      (16'h0000),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out         (out),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .frame_elems (frame_elems)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: a frame of L elements becomes ceil(L/N) beats filled in
    // arrival order, zero padded, with the last one flagged and carrying L.
    task automatic model_frame(input logic [15:0] el[$]);
        int L = el.size();
        for (int b = 0; b * NL < L; b++) begin
            beat_t bt;
            bt.data = '0;
            for (int k = 0; k < NL; k++) begin
                if (b * NL + k < L) bt.data[k*BW +: BW] = el[b*NL + k];
            end
            bt.last = ((b + 1) * NL >= L);
            bt.fe   = 16'(L);
            exp_q.push_back(bt);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [15:0] d, input logic last);
        int guard = 0;
        bit done  = 0;
        in       = d;
        in_valid = 1'b1;
        in_last  = last;
        while (!done) begin
            if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_ready) begin
                done = 1;
            end else begin
                guard++;
                if (guard > 60) begin
                    n_assert++;
                    n_fail++;
                    $error("FAIL accept_timeout: observed in_ready=0 expected element accepted");
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in       = 'x;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [15:0] el[$]);
        model_frame(el);
        for (int i = 0; i < el.size(); i++) begin
            send(el[i], i == el.size() - 1);
            if (rnd_mode && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    // Every handshaken beat is checked against the next expected beat.
    always @(negedge clk) begin
        beat_t bt;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL unexpected_beat: observed beat %h expected none", out);
            end else begin
                bt = exp_q.pop_front();
                chk("beat_data", out, bt.data);
                chk("beat_last", 128'(out_last), 128'(bt.last));
                if (bt.last) chk("frame_elems", 128'(frame_elems), 128'(bt.fe));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] fr[$];
        rst       = 1'b1;
        in        = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid",   128'(out_valid),   128'(0));
        chk("rst_out_last",    128'(out_last),    128'(0));
        chk("rst_out",         out,               128'(0));
        chk("rst_frame_elems", 128'(frame_elems), 128'(0));
        chk("rst_in_ready",    128'(in_ready),    128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 16 x 1.0: two full beats, beat appears one edge after 8th element.
        fr = {};
        for (int i = 0; i < 16; i++) fr.push_back(16'h3C00);
        model_frame(fr);
        for (int i = 0; i < 16; i++) begin
            send(fr[i], i == 15);
            if (i == 6)  chk("t1_no_early_beat", 128'(out_valid), 128'(0));
            if (i == 7)  chk("t1_beat1_latency", 128'({out_valid, out_last}), 128'(2'b10));
            if (i == 14) chk("t1_beat1_retired", 128'(out_valid), 128'(0));
            if (i == 15) chk("t1_beat2_latency", 128'({out_valid, out_last}), 128'(2'b11));
        end
        idle(2);

        // 11 elements: one full beat then 3 lanes + 5 pad.
        fr = {};
        for (int i = 0; i < 11; i++) fr.push_back(16'h4000 + 16'(i));
        send_frame(fr);
        idle(2);

        // Single-element frame.
        fr = {16'hC500};
        send_frame(fr);
        idle(2);

        // Back-to-back frames of 8 and 3 with no idle cycle.
        fr = {};
        for (int i = 0; i < 8; i++) fr.push_back(16'($urandom));
        send_frame(fr);
        fr = {};
        for (int i = 0; i < 3; i++) fr.push_back(16'($urandom));
        send_frame(fr);
        idle(3);

        // Backpressure: hold the first beat of a 12-element frame for 5 cycles.
        fr = {};
        for (int i = 0; i < 12; i++) fr.push_back(16'($urandom));
        model_frame(fr);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(fr[i], 1'b0);
        in       = fr[8];
        in_valid = 1'b1;
        in_last  = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("t5_in_ready_low", 128'(in_ready),  128'(0));
            chk("t5_out_valid",    128'(out_valid), 128'(1));
            chk("t5_out_stable",   out,             exp_q[0].data);
        end
        out_ready = 1'b1;
        for (int i = 8; i < 12; i++) send(fr[i], i == 11);
        idle(3);

        // Reset with a held beat, then with a partial beat; neither survives.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'h1111 + 16'(i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_out_valid", 128'(out_valid), 128'(0));
        chk("t6_async_in_ready",  128'(in_ready),  128'(0));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(16'h2222 + 16'(i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        fr = {};
        for (int i = 0; i < 8; i++) fr.push_back(16'h5000 + 16'(i));
        send_frame(fr);
        idle(3);

        // Randomized frames with random gaps and random backpressure.
        rnd_mode = 1;
        for (int f = 0; f < 12; f++) begin
            fr = {};
            for (int i = 0; i < $urandom_range(1, 20); i++) fr.push_back(16'($urandom));
            send_frame(fr);
        end
        rnd_mode  = 0;
        out_ready = 1'b1;
        idle(5);
        chk("all_beats_delivered", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
